// File: rtl/mem_responder_pkg.sv
// Shared state encoding, counter width and default sizing for the CPU-side
// memory responder; the CPU top level reuses the DEF_* constants.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W       = 4;

  // The memory access fires on the last WAIT cycle, once the wait count is spent.
  function automatic logic access_due(input state_t st, input logic [CNT_W-1:0] cnt);
    return (st == ST_WAIT) && (cnt == {CNT_W{1'b0}});
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/ready bus between the multicycle CPU controller (master) and the
// memory responder (slave).
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;

  modport master (output req, we, addr, wdata, input rdata, ready, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ready, busy);

endinterface

// File: rtl/mem_responder_mem_array.sv
// Synchronous single-port RAM with write enable and a registered read port.
// Contents are not reset; only the read register is.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write; a reset on the same edge drops the write.
  always_ff @(posedge clk) begin
    if (!reset && en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register: cleared by reset, otherwise held until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= {DATA_W{1'b0}};
    end else if (en && !we) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures one request in IDLE, waits LATENCY cycles,
// performs the access, then pulses ready for one cycle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  state_t             state_r;
  logic [CNT_W-1:0]   count_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               we_r;
  logic               ready_r;
  logic               busy_r;
  logic               access_s;

  assign access_s  = access_due(state_r, count_r);
  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;

  // Control FSM; the bus inputs are only looked at in IDLE, so requests are never queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      we_r    <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          if (bus.req) begin
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
            we_r    <= bus.we;
            count_r <= LAT_C;
            busy_r  <= 1'b1;
            state_r <= ST_WAIT;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            ready_r <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          count_r <= {CNT_W{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .en    (access_s),
    .we    (we_r),
    .addr  (addr_r),
    .wdata (wdata_r),
    .rdata (bus.rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a LATENCY=2 and a LATENCY=0 instance
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int total = 0;
  int bad   = 0;

  // Reference model: memory image (addresses 0..15 only), last read value, latency.
  logic [DW-1:0] mem_m [2][16];
  logic [DW-1:0] rd_m  [2];
  int            lat_m [2] = '{2, 0};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int sel, input logic rq, input logic w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (sel == 0) begin
      bus0.req = rq; bus0.we = w; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.req = rq; bus1.we = w; bus1.addr = a; bus1.wdata = d;
    end
  endtask

  task automatic chk_outs(input int sel, input string tag, input logic eb, input logic er);
    logic [DW-1:0] b, r, q;
    b = (sel == 0) ? DW'(bus0.busy)  : DW'(bus1.busy);
    r = (sel == 0) ? DW'(bus0.ready) : DW'(bus1.ready);
    q = (sel == 0) ? bus0.rdata : bus1.rdata;
    chk($sformatf("%s_d%0d_busy", tag, sel), b, DW'(eb));
    chk($sformatf("%s_d%0d_ready", tag, sel), r, DW'(er));
    chk($sformatf("%s_d%0d_rdata", tag, sel), q, rd_m[sel]);
  endtask

  // One full request; after edge k: busy for k<=L+1, ready only at k=L+1,
  // the access result is visible from edge L+1 on.
  task automatic transact(input int sel, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic disturb, input string tag);
    int L;
    L = lat_m[sel];
    @(negedge clk);
    drv(sel, 1'b1, w, a, d);
    for (int k = 0; k <= L + 2; k++) begin
      @(negedge clk);
      if (k == L + 1) begin
        if (w) mem_m[sel][a[3:0]] = d;
        else   rd_m[sel] = mem_m[sel][a[3:0]];
      end
      chk_outs(sel, $sformatf("%s_e%0d", tag, k), k <= L + 1, k == L + 1);
      if (disturb && k < L + 2)
        drv(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom), DW'($urandom));
      else
        drv(sel, 1'b0, 1'b0, a, d);
    end
  endtask

  // Start a write on dut0 and assert reset so that it lands on edge r_edge.
  task automatic write_reset(input logic [AW-1:0] a, input logic [DW-1:0] d, input int r_edge);
    @(negedge clk);
    drv(0, 1'b1, 1'b1, a, d);
    for (int k = 0; k < r_edge; k++) begin
      @(negedge clk);
      drv(0, 1'b0, 1'b0, a, d);
      chk(
        $sformatf("wrst%0d_e%0d_busy", r_edge, k), DW'(bus0.busy), DW'(1'b1));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_m[0] = '0;
    rd_m[1] = '0;
    chk_outs(0, $sformatf("wrst%0d_after", r_edge), 1'b0, 1'b0);
    chk_outs(1, $sformatf("wrst%0d_after", r_edge), 1'b0, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] acc_a;
    int            ph;

    reset = 1'b1;
    drv(0, 1'b0, 1'b0, '0, '0);
    drv(1, 1'b0, 1'b0, '0, '0);
    rd_m[0] = '0;
    rd_m[1] = '0;

    // Reset held two cycles, then three idle cycles.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) reset = 1'b0;
      chk_outs(0, $sformatf("rst_idle%0d", k), 1'b0, 1'b0);
      chk_outs(1, $sformatf("rst_idle%0d", k), 1'b0, 1'b0);
    end

    // Directed: write then read back, LATENCY=2.
    transact(0, 1'b1, 8'd5, 32'hDEADBEEF, 1'b0, "wr5");
    transact(0, 1'b0, 8'd5, 32'h0, 1'b0, "rd5");
    transact(0, 1'b1, 8'd9, 32'h0, 1'b0, "wr9");

    // Ignore while busy: retarget to addr 9 and re-pulse req during WAIT.
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 8'd5, 32'h0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) rd_m[0] = mem_m[0][5];
      chk_outs(0, $sformatf("busyign_e%0d", k), k <= 3, k == 3);
      drv(0, (k == 0 || k == 2), 1'b1, 8'd9, 32'h12345678);
      if (k == 4) drv(0, 1'b0, 1'b0, 8'd9, 32'h0);
    end
    chk("busyign_val", bus0.rdata, 32'hDEADBEEF);

    // Reset mid-write (during WAIT, and on the access edge itself).
    transact(0, 1'b1, 8'd7, 32'h11, 1'b0, "wr7");
    write_reset(8'd7, 32'h22, 1);
    transact(0, 1'b0, 8'd7, 32'h0, 1'b0, "rd7a");
    write_reset(8'd7, 32'h33, 3);
    transact(0, 1'b0, 8'd7, 32'h0, 1'b0, "rd7b");

    // Preload the low 16 words of both instances so every later read is defined.
    for (int i = 0; i < 16; i++) begin
      transact(0, 1'b1, AW'(i), DW'($urandom), 1'b0, "pre0");
      transact(1, 1'b1, AW'(i), DW'($urandom), 1'b0, "pre1");
    end

    // Back-to-back reads with req held for 20 edges: accept every 5th edge.
    a = AW'($urandom_range(0, 15));
    acc_a = a;
    @(negedge clk);
    drv(0, 1'b1, 1'b0, a, '0);
    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 0) acc_a = a;
      @(negedge clk);
      ph = k % 5;
      if (ph == 3) rd_m[0] = mem_m[0][acc_a[3:0]];
      chk_outs(0, $sformatf("b2b_e%0d", k), ph <= 3, ph == 3);
      a = AW'($urandom_range(0, 15));
      drv(0, k < 19, 1'b0, a, '0);
    end

    // LATENCY=0 directed read, then randomized traffic on both instances.
    transact(1, 1'b0, 8'd3, 32'h0, 1'b0, "l0rd");
    for (int i = 0; i < 16; i++) begin
      transact(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
               DW'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd0_%0d", i));
      transact(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
               DW'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd1_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port word memory that answers the multicycle CPU's load, store and fetch requests through a request/ready handshake with a parameterised number of wait states. It sits on the memory side of the CPU controller. The controller raises `req` in its fetch, memory-read and memory-write states and holds there until `ready` pulses. This lets the CPU tolerate slow memory instead of relying on fixed single-cycle access.

## Interface
- `DATA_W`, default 32: data word width.
- `ADDR_W`, default 8: word address width; depth is 2^ADDR_W words, so every address is in range.
- `LATENCY`, default 2: wait-state count. Legal range 0..15; the counter is 4 bits.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `req`: input, 1 bit. Request valid; sampled only in IDLE.
- `we`: input, 1 bit. 1 = write, 0 = read (fetch and load both use read).
- `addr`: input, ADDR_W bits. Word address.
- `wdata`: input, DATA_W bits. Store data.
- `rdata`: output, DATA_W bits. Registered read data.
- `ready`: output, 1 bit. One-cycle completion pulse.
- `busy`: output, 1 bit. High whenever state ≠ IDLE.

## Operation
- **Reset values:** state=IDLE, count=0, `rdata`=0, `ready`=0, `busy`=0. Memory contents are not reset.
- **IDLE, `req`=1:** capture `addr`, `we` and `wdata` into request registers. Load count=LATENCY. Go to WAIT.
- **IDLE, `req`=0:** stay in IDLE.
- **WAIT, count≠0:** count−1, stay in WAIT.
- **WAIT, count==0:** perform the access using the captured registers.
  - Write: mem[addr_q]←wdata_q; `rdata` unchanged.
  - Read: `rdata`←mem[addr_q].
  - Then go to DONE.
- **DONE:** `ready`=1 for exactly this one cycle. Go to IDLE unconditionally.
- **Requests while busy:** `req` and all input changes in WAIT or DONE are ignored. Requests are never queued.
- **`rdata` hold:** `rdata` holds its value until the next read access, including across writes and idle periods.
- **Reset mid-operation:** reset has priority on every edge. Any state returns to IDLE.
  - A write whose access edge coincides with reset, or has not yet occurred, is dropped; memory is unchanged.
  - `rdata` returns to 0.

## Timing
- **Edge numbering:** edge 0 is the edge at which `req` is sampled in IDLE.
- **`busy`:** rises after edge 0.
- **WAIT:** decrements on edges 1..LATENCY; the access occurs on edge LATENCY+1.
- **`ready` and read `rdata`:** `ready` is high from edge LATENCY+1 to edge LATENCY+2. Read `rdata` is valid from edge LATENCY+1.
- **Back to IDLE:** at edge LATENCY+2 `busy` falls.
- **Next request:** the earliest next request is sampled at edge LATENCY+3.
- **Throughput:** one access per LATENCY+3 cycles with `req` held high.
- **LATENCY=0:** WAIT lasts one cycle; `ready` is high between edges 1 and 2.
- **Output registering:** all outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - State encodings: ST_IDLE=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2. Encoding 2'd3 is illegal and maps to IDLE.
  - Default DATA_W, ADDR_W and LATENCY constants for reuse by the CPU top level.
- One sub-module, `mem_array`: a synchronous single-port RAM with write enable and registered read, instantiated with DATA_W/ADDR_W.
- The FSM, counter and request registers stay in `mem_responder`.

## Test plan
- **Reset idle:** hold `reset` 2 cycles, then idle 3 cycles → `ready`=0, `busy`=0, `rdata`=0 throughout.
- **Write then read, LATENCY=2:**
  - Write 0xDEADBEEF to addr 5 → `ready` pulses once, between edges 3 and 4.
  - Then read addr 5 → `rdata`=0xDEADBEEF with `ready` at edge 3 of that request; `rdata` still holds after `ready` falls.
- **Ignore while busy:**
  - Issue a read of addr 5 while addr 9 holds 0x0.
  - During WAIT, change `addr` to 9 and pulse `req` → result is 0xDEADBEEF and exactly one `ready` pulse.
- **Reset mid-write:**
  - Addr 7 holds 0x11. Start a write of 0x22 to addr 7 and assert `reset` during WAIT.
  - Then read addr 7 → 0x11; `rdata`=0 immediately after reset.
- **LATENCY=0 instance:** read request → `ready` high between edges 1 and 2; `busy` low after edge 2.
- **Back-to-back reads, LATENCY=2:** hold `req` high for 20 cycles → requests accepted at edges 0, 5, 10, 15; `ready` pulses at edges 3, 8, 13, 18.
